ex_muldiv_unit: RTL

// - EX-stage iterative multiply/divide unit with architectural HI/LO registers.
// - Consumes the ReadData1/ReadData2 operands and the decoded muldiv op that the ID/EX pipeline register delivers.
// - Runs MULT/MULTU/DIV/DIVU over 32 iterations and holds HI/LO for MFHI/MFLO.
// - Raises stall_o to the hazard unit while a dependent instruction must wait.

---
 rtl/ex_muldiv_unit_pkg.sv | 24 ++
 rtl/ex_muldiv_unit_if.sv | 27 ++
 rtl/ex_muldiv_unit_step.sv | 33 +++
 rtl/ex_muldiv_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Operand/control/result bundle between the ID/EX stage and the muldiv unit.
interface ex_muldiv_if #(parameter int XLEN = 32);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] rs_data_i;
  logic [XLEN-1:0] rt_data_i;
  logic            mthi_i;
  logic            mtlo_i;
  logic [XLEN-1:0] wdata_i;
  logic            mf_req_i;
  logic            flush_i;
  logic            busy_o;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] hi_o;
  logic [XLEN-1:0] lo_o;

  modport master (
    output start_i, op_i, rs_data_i, rt_data_i, mthi_i, mtlo_i, wdata_i, mf_req_i, flush_i,
    input  busy_o, stall_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, rs_data_i, rt_data_i, mthi_i, mtlo_i, wdata_i, mf_req_i, flush_i,
    output busy_o, stall_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv_unit_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  mode_e             mode_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] add_s;
  logic [XLEN:0] rem_s;
  logic [XLEN:0] sub_s;

  always_comb begin
    // Multiply: conditional add into the upper half, then shift right with the carry.
    add_s = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    // Divide: partial remainder after the left shift; bit XLEN of sub_s is the borrow.
    rem_s = acc_i[2*XLEN-1:XLEN-1];
    sub_s = rem_s - {1'b0, opnd_i};
    acc_o = acc_i;
    if (mode_i == MODE_MUL) begin
      acc_o = {add_s, acc_i[XLEN-1:1]};
    end else if (!sub_s[XLEN]) begin
      acc_o = {sub_s[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {rem_s[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and hazard stall.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  ex_muldiv_if.slave  bus
);

  state_e             state_q;
  mode_e              mode_q;
  logic               busy_q;
  logic               done_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*XLEN-1:0]  acc_q;
  logic [2*XLEN-1:0]  acc_d;
  logic [XLEN-1:0]    opnd_q;
  logic [XLEN-1:0]    hi_q;
  logic [XLEN-1:0]    lo_q;

  logic               signed_op;
  logic               div_op;
  logic               rs_neg;
  logic               rt_neg;
  logic               div_zero;
  logic [XLEN-1:0]    rs_abs;
  logic [XLEN-1:0]    rt_abs;
  logic [XLEN-1:0]    dvd_d;
  logic [2*XLEN-1:0]  prod_fix;
  logic [XLEN-1:0]    hi_fix;
  logic [XLEN-1:0]    lo_fix;

  // Launch-time operand conditioning; div-by-zero keeps the raw dividend so HI ends up as rs.
  always_comb begin
    signed_op = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
    div_op    = (bus.op_i == OP_DIV)  || (bus.op_i == OP_DIVU);
    rs_neg    = signed_op & bus.rs_data_i[XLEN-1];
    rt_neg    = signed_op & bus.rt_data_i[XLEN-1];
    rs_abs    = rs_neg ? -bus.rs_data_i : bus.rs_data_i;
    rt_abs    = rt_neg ? -bus.rt_data_i : bus.rt_data_i;
    div_zero  = div_op && (bus.rt_data_i == '0);
    dvd_d     = div_zero ? bus.rs_data_i : rs_abs;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .mode_i (mode_q),
    .acc_o  (acc_d)
  );

  // Sign correction applied on the FIX cycle.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    hi_fix   = prod_fix[2*XLEN-1:XLEN];
    lo_fix   = prod_fix[XLEN-1:0];
    if (mode_q == MODE_DIV) begin
      lo_fix = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      hi_fix = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_MUL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            if (!bus.flush_i) begin
              state_q   <= ST_RUN;
              busy_q    <= 1'b1;
              cnt_q     <= '0;
              mode_q    <= div_op ? MODE_DIV : MODE_MUL;
              opnd_q    <= div_op ? rt_abs : rs_abs;
              acc_q     <= {{XLEN{1'b0}}, div_op ? dvd_d : rt_abs};
              neg_res_q <= (rs_neg ^ rt_neg) & ~div_zero;
              neg_rem_q <= rs_neg & div_op & ~div_zero;
            end
          end else begin
            if (bus.mthi_i) hi_q <= bus.wdata_i;
            if (bus.mtlo_i) lo_q <= bus.wdata_i;
          end
        end
        ST_RUN: begin
          if (bus.flush_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN-1)) state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (!bus.flush_i) begin
            hi_q   <= hi_fix;
            lo_q   <= lo_fix;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
  assign bus.stall_o = busy_q & (bus.start_i | bus.mf_req_i | bus.mthi_i | bus.mtlo_i);

endmodule
